// File: rtl/rc_pulse_decoder.sv
// RC-servo pulse receiver: measures the high time of pwm_in in microseconds and
// maps it to an 8-bit position code, flagging bad widths and loss of signal.
module rc_pulse_decoder #(
    parameter int TICKS_PER_US  = 50,
    parameter int PULSE_MIN_US  = 1000,
    parameter int STEP_SHIFT    = 2,
    parameter int GLITCH_MIN_US = 500,
    parameter int WIDTH_MAX_US  = 2500,
    parameter int TIMEOUT_US    = 25000
) (
    input  logic       clk_50,
    input  logic       reset,
    input  logic       pwm_in,
    output logic [7:0] pos,
    output logic       pos_valid,
    output logic       err_width,
    output logic       signal_lost
);
    localparam int PW = $clog2(TICKS_PER_US + 1);
    localparam logic [PW-1:0] L_PRE_LAST = PW'(TICKS_PER_US - 1);
    localparam logic [11:0]   L_MIN      = 12'(PULSE_MIN_US);
    localparam logic [11:0]   L_GLITCH   = 12'(GLITCH_MIN_US);
    localparam logic [11:0]   L_MAX      = 12'(WIDTH_MAX_US);
    localparam logic [14:0]   L_TMO_LAST = 15'(TIMEOUT_US - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_DONE} state_t;

    state_t        r_state, w_next;
    logic          r_s1, r_s2, r_s3;
    logic          w_rise, w_fall, w_tick, w_tmo_hit;
    logic [PW-1:0] r_pre;
    logic [11:0]   r_width, w_excess, w_steps;
    logic [14:0]   r_tmo;
    logic [1:0]    r_prime;
    logic [7:0]    w_mapped;
    logic          w_ev_valid, w_ev_err;
    logic [7:0]    w_ev_pos;
    logic          r_ev_valid, r_ev_err;
    logic [7:0]    r_ev_pos;

    assign w_rise    = r_s2 & ~r_s3;
    assign w_fall    = ~r_s2 & r_s3;
    assign w_tick    = (r_pre == L_PRE_LAST);
    assign w_tmo_hit = w_tick & ~w_rise & (r_tmo == L_TMO_LAST);

    // Clamp before truncation so 1200 us over the minimum reads 255, not 300 mod 256.
    assign w_excess = r_width - L_MIN;
    assign w_steps  = w_excess >> STEP_SHIFT;
    assign w_mapped = (w_steps > 12'd255) ? 8'hFF : w_steps[7:0];

    always_ff @(posedge clk_50 or negedge reset) begin
        if (!reset) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_s3    <= 1'b0;
            r_pre   <= '0;
            r_width <= '0;
            r_tmo   <= '0;
            r_prime <= '0;
            r_state <= S_IDLE;
        end else begin
            r_s1    <= pwm_in;
            r_s2    <= r_s1;
            r_s3    <= r_s2;
            r_state <= w_next;
            if (w_rise || w_tick) r_pre <= '0;
            else                  r_pre <= r_pre + 1'b1;
            if (w_rise)
                r_width <= '0;
            else if (r_state == S_HIGH && w_tick && r_width != 12'hFFF)
                r_width <= r_width + 12'd1;
            if (w_rise)
                r_tmo <= '0;
            else if (w_tick && r_tmo != 15'h7FFF)
                r_tmo <= r_tmo + 15'd1;
            // The synchroniser resets to 0, so give it two edges of real samples
            // before trusting a low level in S_IDLE.
            if (r_state == S_IDLE && r_prime != 2'd2)
                r_prime <= r_prime + 2'd1;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_ev_valid = 1'b0;
        w_ev_err   = 1'b0;
        w_ev_pos   = 8'h00;
        case (r_state)
            S_IDLE: if (r_prime == 2'd2 && !r_s2) w_next = S_LOW;
            S_LOW:  if (w_rise) w_next = S_HIGH;
            S_HIGH: begin
                if (r_width > L_MAX) begin
                    w_ev_err = 1'b1;
                    w_next   = S_LOW;
                end else if (w_fall) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_LOW;
                if (r_width < L_GLITCH) begin
                    w_ev_err = 1'b1;
                end else begin
                    w_ev_valid = 1'b1;
                    w_ev_pos   = (r_width < L_MIN) ? 8'h00 : w_mapped;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // One event stage ahead of the outputs sets the falling-edge-to-strobe latency.
    always_ff @(posedge clk_50 or negedge reset) begin
        if (!reset) begin
            r_ev_valid  <= 1'b0;
            r_ev_err    <= 1'b0;
            r_ev_pos    <= 8'h00;
            pos         <= 8'h00;
            pos_valid   <= 1'b0;
            err_width   <= 1'b0;
            signal_lost <= 1'b1;
        end else begin
            r_ev_valid <= w_ev_valid;
            r_ev_err   <= w_ev_err;
            r_ev_pos   <= w_ev_pos;
            pos_valid  <= r_ev_valid;
            err_width  <= r_ev_err;
            if (r_ev_valid) pos <= r_ev_pos;
            if (r_ev_valid)     signal_lost <= 1'b0;
            else if (w_tmo_hit) signal_lost <= 1'b1;
        end
    end
endmodule

// File: tb/tb_rc_pulse_decoder.sv
// Directed bench for rc_pulse_decoder, run with 2 clocks per us and a 3000 us
// timeout so the long-gap scenarios stay short.
module tb_rc_pulse_decoder;
    localparam int T = 2;

    logic       clk_50 = 1'b0;
    logic       reset  = 1'b0;
    logic       pwm_in = 1'b0;
    logic [7:0] pos;
    logic       pos_valid, err_width, signal_lost;

    int errs = 0, checks = 0;
    int nv = 0, ne = 0, n_both = 0;
    int nv0, ne0;
    int hi_tab  [4] = '{1000, 2020, 2200, 800};
    int pos_tab [4] = '{0, 255, 255, 0};

    rc_pulse_decoder #(
        .TICKS_PER_US(T),
        .PULSE_MIN_US(1000),
        .STEP_SHIFT(2),
        .GLITCH_MIN_US(500),
        .WIDTH_MAX_US(2500),
        .TIMEOUT_US(3000)
    ) dut (
        .clk_50(clk_50),
        .reset(reset),
        .pwm_in(pwm_in),
        .pos(pos),
        .pos_valid(pos_valid),
        .err_width(err_width),
        .signal_lost(signal_lost)
    );

    always #5 clk_50 = ~clk_50;

    always @(negedge clk_50) begin
        if (pos_valid) nv++;
        if (err_width) ne++;
        if (pos_valid && err_width) n_both++;
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_us(input int n);
        repeat (n * T) @(negedge clk_50);
    endtask

    task automatic pulse(input int hi, input int lo);
        pwm_in = 1'b1;
        wait_us(hi);
        pwm_in = 1'b0;
        wait_us(lo);
    endtask

    initial begin
        repeat (3) @(negedge clk_50);
        check("rst_pos", int'(pos), 0);
        check("rst_valid", int'(pos_valid), 0);
        check("rst_err", int'(err_width), 0);
        check("rst_lost", int'(signal_lost), 1);
        reset = 1'b1;
        wait_us(10);

        // 1: repeated 1500 us pulses
        pulse(1500, 200);
        check("t1_pos1", int'(pos), 125);
        check("t1_lost_clr", int'(signal_lost), 0);
        pulse(1500, 200);
        pulse(1500, 200);
        check("t1_nvalid", nv, 3);
        check("t1_pos3", int'(pos), 125);

        // 2: map endpoints and clamps
        for (int i = 0; i < 4; i++) begin
            nv0 = nv;
            pulse(hi_tab[i], 200);
            check("t2_pos", int'(pos), pos_tab[i]);
            check("t2_nvalid", nv - nv0, 1);
        end
        check("t2_no_err", ne, 0);
        pulse(1500, 200);
        check("t2_pos_restore", int'(pos), 125);

        // 3: glitch and overlong pulses
        nv0 = nv; ne0 = ne;
        pulse(300, 200);
        check("t3_glitch_err", ne - ne0, 1);
        check("t3_glitch_pos", int'(pos), 125);
        pwm_in = 1'b1;
        wait_us(2495);
        check("t3_wide_early", ne - ne0, 1);
        wait_us(10);
        check("t3_wide_err", ne - ne0, 2);
        wait_us(195);
        pwm_in = 1'b0;
        wait_us(200);
        check("t3_wide_single", ne - ne0, 2);
        check("t3_no_valid", nv - nv0, 0);
        check("t3_pos_hold", int'(pos), 125);

        // 4: loss of signal and recovery
        pulse(1500, 1400);
        check("t4_lost_before", int'(signal_lost), 0);
        check("t4_pos", int'(pos), 125);
        wait_us(200);
        check("t4_lost_set", int'(signal_lost), 1);
        wait_us(900);
        check("t4_pos_hold", int'(pos), 125);
        pwm_in = 1'b1;
        wait_us(1000);
        check("t4_bare_rise", int'(signal_lost), 1);
        wait_us(700);
        pwm_in = 1'b0;
        wait_us(200);
        check("t4_pos175", int'(pos), 175);
        check("t4_lost_clr", int'(signal_lost), 0);

        // 5: reset mid-pulse, then exact latency from the falling edge
        nv0 = nv;
        pwm_in = 1'b1;
        wait_us(400);
        reset = 1'b0;
        wait_us(5);
        check("t5_rst_pos", int'(pos), 0);
        check("t5_rst_lost", int'(signal_lost), 1);
        reset = 1'b1;
        wait_us(1095);
        pwm_in = 1'b0;
        wait_us(200);
        check("t5_ignored", nv - nv0, 0);
        pwm_in = 1'b1;
        wait_us(1200);
        pwm_in = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk_50);
            @(negedge clk_50);
            check($sformatf("t5_lat%0d", i), int'(pos_valid), (i == 4) ? 1 : 0);
        end
        check("t5_pos50", int'(pos), 50);
        check("t5_lost_clr", int'(signal_lost), 0);
        wait_us(200);

        // 6: stuck high from idle
        nv0 = nv; ne0 = ne;
        pwm_in = 1'b1;
        wait_us(4000);
        check("t6_err", ne - ne0, 1);
        check("t6_lost", int'(signal_lost), 1);
        pwm_in = 1'b0;
        wait_us(200);
        check("t6_err_single", ne - ne0, 1);
        check("t6_no_valid", nv - nv0, 0);
        check("t6_pos_hold", int'(pos), 50);
        check("excl_strobes", n_both, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
